// File: rtl/controlador_interrupciones_if.sv
// Bus between the CPU side and the interrupt controller: source lines,
// mask writes, ack/eoi handshake and the controller's status outputs.
interface controlador_interrupciones_if #(
   parameter int N_FUENTES = 4,
   parameter int VEC_W     = 10
);
   logic [N_FUENTES-1:0] irq_in;
   logic                 we_mask;
   logic [N_FUENTES-1:0] mask_in;
   logic                 ack;
   logic                 eoi;
   logic                 interrupcion;
   logic [VEC_W-1:0]     vector;
   logic [N_FUENTES-1:0] mask;
   logic [N_FUENTES-1:0] pendiente;
   logic [N_FUENTES-1:0] en_servicio;

   modport master (
      output irq_in, we_mask, mask_in, ack, eoi,
      input  interrupcion, vector, mask, pendiente, en_servicio
   );

   modport slave (
      input  irq_in, we_mask, mask_in, ack, eoi,
      output interrupcion, vector, mask, pendiente, en_servicio
   );
endinterface

// File: rtl/controlador_interrupciones.sv
// Prioritised, maskable, non-nesting interrupt controller: latches rising
// edges, requests the lowest unmasked pending index and waits for ack/eoi.
module controlador_interrupciones #(
   parameter int                 N_FUENTES = 4,
   parameter int                 VEC_W     = 10,
   parameter logic [VEC_W-1:0]   VEC_BASE  = 10'd1000,
   parameter int                 VEC_PASO  = 4
) (
   input logic clk,
   input logic reset,
   controlador_interrupciones_if.slave bus
);
   localparam int IDX_W = (N_FUENTES > 1) ? $clog2(N_FUENTES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, SERVICIO} estado_t;

   estado_t              estado;
   logic [IDX_W-1:0]     idx;
   logic [N_FUENTES-1:0] prev;
   logic [N_FUENTES-1:0] pendiente;
   logic [N_FUENTES-1:0] mask;
   logic [N_FUENTES-1:0] en_servicio;
   logic                 interrupcion;
   logic [VEC_W-1:0]     vector;

   logic [N_FUENTES-1:0] flancos;
   logic [N_FUENTES-1:0] candidatos;
   logic [N_FUENTES-1:0] borrar;
   logic [IDX_W-1:0]     ganador;
   logic [VEC_W-1:0]     vec_calc;
   logic                 aceptado;

   assign flancos    = bus.irq_in & ~prev;
   assign candidatos = pendiente & ~mask;
   assign aceptado   = (estado == REQ) && bus.ack;

   // Descending scan so the lowest set index is the one left standing.
   always_comb begin
      ganador = '0;
      for (int i = N_FUENTES - 1; i >= 0; i--)
         if (candidatos[i]) ganador = IDX_W'(i);
   end

   assign vec_calc = VEC_W'(32'(VEC_BASE) + 32'(ganador) * 32'(VEC_PASO));
   assign borrar   = aceptado ? (N_FUENTES'(1) << idx) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado       <= IDLE;
         idx          <= '0;
         prev         <= '0;
         pendiente    <= '0;
         mask         <= '1;
         en_servicio  <= '0;
         interrupcion <= 1'b0;
         vector       <= VEC_BASE;
      end else begin
         prev <= bus.irq_in;
         if (bus.we_mask) mask <= bus.mask_in;
         // A new edge on the source being acknowledged survives the clear.
         pendiente <= (pendiente & ~borrar) | flancos;
         case (estado)
            IDLE: begin
               if (|candidatos) begin
                  idx          <= ganador;
                  vector       <= vec_calc;
                  interrupcion <= 1'b1;
                  estado       <= REQ;
               end
            end
            REQ: begin
               if (bus.ack) begin
                  en_servicio  <= N_FUENTES'(1) << idx;
                  interrupcion <= 1'b0;
                  estado       <= SERVICIO;
               end
            end
            SERVICIO: begin
               if (bus.eoi) begin
                  en_servicio <= '0;
                  estado      <= IDLE;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

   assign bus.interrupcion = interrupcion;
   assign bus.vector       = vector;
   assign bus.mask         = mask;
   assign bus.pendiente    = pendiente;
   assign bus.en_servicio  = en_servicio;
endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed bench for controlador_interrupciones with hand-computed expectations.
module tb_controlador_interrupciones;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   controlador_interrupciones_if #(.N_FUENTES(4), .VEC_W(10)) bus ();

   controlador_interrupciones #(
      .N_FUENTES(4), .VEC_W(10), .VEC_BASE(10'd1000), .VEC_PASO(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Step past the next rising edge; inputs set afterwards are sampled on the following edge.
   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic pulso_ack();
      bus.ack = 1'b1; ciclo(); bus.ack = 1'b0;
   endtask

   task automatic pulso_eoi();
      bus.eoi = 1'b1; ciclo(); bus.eoi = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.irq_in = '0; bus.we_mask = 1'b0; bus.mask_in = '0;
      bus.ack = 1'b0; bus.eoi = 1'b0;
      ciclo(); ciclo();
      chk("rst_int",  32'(bus.interrupcion), 0);
      chk("rst_vec",  32'(bus.vector),       1000);
      chk("rst_mask", 32'(bus.mask),         4'b1111);
      chk("rst_pend", 32'(bus.pendiente),    0);
      chk("rst_serv", 32'(bus.en_servicio),  0);
      reset = 1'b0;

      // Single source 2
      bus.we_mask = 1'b1; bus.mask_in = 4'b0000; ciclo(); bus.we_mask = 1'b0;
      chk("t1_mask", 32'(bus.mask), 0);
      bus.irq_in = 4'b0100; ciclo(); bus.irq_in = '0;
      chk("t1_pend", 32'(bus.pendiente), 4'b0100);
      chk("t1_int0", 32'(bus.interrupcion), 0);
      ciclo();
      chk("t1_int1", 32'(bus.interrupcion), 1);
      chk("t1_vec",  32'(bus.vector), 1008);
      pulso_ack();
      chk("t1_ack_int",  32'(bus.interrupcion), 0);
      chk("t1_ack_serv", 32'(bus.en_servicio), 4'b0100);
      chk("t1_ack_pend", 32'(bus.pendiente), 0);
      pulso_eoi();
      chk("t1_eoi_serv", 32'(bus.en_servicio), 0);
      ciclo();
      chk("t1_idle_int", 32'(bus.interrupcion), 0);

      // Sources 3 and 1 together
      bus.irq_in = 4'b1010; ciclo(); bus.irq_in = '0;
      chk("t2_pend", 32'(bus.pendiente), 4'b1010);
      ciclo();
      chk("t2_int_a", 32'(bus.interrupcion), 1);
      chk("t2_vec_a", 32'(bus.vector), 1004);
      pulso_ack();
      chk("t2_pend_a", 32'(bus.pendiente), 4'b1000);
      chk("t2_serv_a", 32'(bus.en_servicio), 4'b0010);
      pulso_eoi();
      chk("t2_int_gap", 32'(bus.interrupcion), 0);
      ciclo();
      chk("t2_int_b", 32'(bus.interrupcion), 1);
      chk("t2_vec_b", 32'(bus.vector), 1012);
      pulso_ack(); pulso_eoi();
      chk("t2_pend_end", 32'(bus.pendiente), 0);
      chk("t2_serv_end", 32'(bus.en_servicio), 0);

      // Masked after reset, then unmasked
      reset = 1'b1; ciclo(); reset = 1'b0;
      bus.irq_in = 4'b0001; ciclo(); bus.irq_in = '0;
      chk("t3_pend", 32'(bus.pendiente), 4'b0001);
      ciclo();
      chk("t3_int_masked", 32'(bus.interrupcion), 0);
      bus.we_mask = 1'b1; bus.mask_in = 4'b0000; ciclo(); bus.we_mask = 1'b0;
      chk("t3_int_wr", 32'(bus.interrupcion), 0);
      ciclo();
      chk("t3_int", 32'(bus.interrupcion), 1);
      chk("t3_vec", 32'(bus.vector), 1000);
      pulso_ack(); pulso_eoi();

      // Higher-priority event while in REQ, plus ignored eoi in REQ
      bus.irq_in = 4'b0100; ciclo(); bus.irq_in = '0; ciclo();
      chk("t4_vec_a", 32'(bus.vector), 1008);
      bus.irq_in = 4'b0001; bus.we_mask = 1'b1; bus.mask_in = 4'b0100;
      ciclo(); bus.irq_in = '0; bus.we_mask = 1'b0;
      chk("t4_vec_hold", 32'(bus.vector), 1008);
      chk("t4_pend", 32'(bus.pendiente), 4'b0101);
      chk("t4_int_hold", 32'(bus.interrupcion), 1);
      bus.we_mask = 1'b1; bus.mask_in = 4'b0000; ciclo(); bus.we_mask = 1'b0;
      pulso_eoi();
      chk("t4_eoi_req", 32'(bus.interrupcion), 1);
      pulso_ack();
      chk("t4_serv", 32'(bus.en_servicio), 4'b0100);
      chk("t4_pend2", 32'(bus.pendiente), 4'b0001);
      pulso_eoi(); ciclo();
      chk("t4_int_b", 32'(bus.interrupcion), 1);
      chk("t4_vec_b", 32'(bus.vector), 1000);
      pulso_ack(); pulso_eoi();

      // Re-trigger of source 1 during service; stray ack/eoi
      bus.irq_in = 4'b0010; ciclo(); bus.irq_in = '0; ciclo();
      chk("t5_vec", 32'(bus.vector), 1004);
      pulso_ack();
      chk("t5_serv", 32'(bus.en_servicio), 4'b0010);
      bus.irq_in = 4'b0010; ciclo(); bus.irq_in = '0;
      chk("t5_pend", 32'(bus.pendiente), 4'b0010);
      chk("t5_int0", 32'(bus.interrupcion), 0);
      pulso_ack();
      chk("t5_ack_serv", 32'(bus.en_servicio), 4'b0010);
      chk("t5_ack_pend", 32'(bus.pendiente), 4'b0010);
      ciclo();
      chk("t5_int_wait", 32'(bus.interrupcion), 0);
      pulso_eoi();
      chk("t5_eoi_serv", 32'(bus.en_servicio), 0);
      ciclo();
      chk("t5_rereq", 32'(bus.interrupcion), 1);
      chk("t5_rereq_vec", 32'(bus.vector), 1004);
      pulso_ack(); pulso_eoi();
      pulso_ack();
      chk("t5_idle_ack_serv", 32'(bus.en_servicio), 0);
      chk("t5_idle_ack_int",  32'(bus.interrupcion), 0);
      pulso_eoi();
      chk("t5_idle_eoi", 32'(bus.en_servicio), 0);

      // Edge coinciding with ack on the same source; ack+eoi together
      bus.irq_in = 4'b0010; ciclo(); bus.irq_in = '0; ciclo();
      chk("t6_int", 32'(bus.interrupcion), 1);
      bus.irq_in = 4'b0010; bus.ack = 1'b1; bus.eoi = 1'b1;
      ciclo(); bus.irq_in = '0; bus.ack = 1'b0; bus.eoi = 1'b0;
      chk("t6_pend_set", 32'(bus.pendiente), 4'b0010);
      chk("t6_serv", 32'(bus.en_servicio), 4'b0010);
      pulso_eoi(); ciclo();
      chk("t6_rereq", 32'(bus.interrupcion), 1);

      // Asynchronous reset while in REQ
      #2 reset = 1'b1; #1;
      chk("t7_int",  32'(bus.interrupcion), 0);
      chk("t7_serv", 32'(bus.en_servicio), 0);
      chk("t7_pend", 32'(bus.pendiente), 0);
      chk("t7_mask", 32'(bus.mask), 4'b1111);
      chk("t7_vec",  32'(bus.vector), 1000);
      ciclo(); reset = 1'b0; ciclo();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/controlador_interrupciones.md
Name: controlador_interrupciones

Overview:
- Prioritised, maskable interrupt controller in front of the CPU's single `interrupcion` input.
- Latches rising-edge events from N peripheral sources and selects the highest-priority unmasked one.
- Raises `interrupcion` with a vector address, and holds further requests until the CPU acknowledges and signals end-of-interrupt.
- No nesting: one interrupt in service at a time.

Parameters:
- N_FUENTES, 4, number of interrupt sources (2..8); index 0 = highest priority.
- VEC_W, 10, width of vector address (matches program counter width).
- VEC_BASE, 10'd1000, vector address of source 0.
- VEC_PASO, 4, address stride between consecutive source vectors.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  N_FUENTES  source request lines; synchronous to clk; rising-edge triggered.
- we_mask  in  1  write strobe for the mask register.
- mask_in  in  N_FUENTES  new mask value; 1 = source masked.
- ack  in  1  CPU accepted the request (one-cycle pulse).
- eoi  in  1  CPU finished the ISR (one-cycle pulse).
- interrupcion  out  1  request to CPU.
- vector  out  VEC_W  ISR address for the current or last selected source.
- mask  out  N_FUENTES  current mask register.
- pendiente  out  N_FUENTES  latched pending events.
- en_servicio  out  N_FUENTES  one-hot in-service source; zero when none.

Behaviour:
- Reset values (asynchronous): interrupcion=0, vector=VEC_BASE, mask=all 1s, pendiente=0, en_servicio=0, edge register prev=0, state=IDLE, selected index=0.
  - Because prev resets to 0, an irq_in bit that is high at reset release produces one event.
- Edge detection: each cycle prev<=irq_in. An edge on bit i is irq_in[i]&~prev[i] and sets pendiente[i] at that clock edge.
  - Pending does not count: repeated edges while already pending are lost.
- Mask: when we_mask=1, mask<=mask_in at the clock edge. Masking never clears pendiente; the event waits until unmasked.
- Candidate set: pendiente & ~mask. Winner = lowest set index.
- FSM state IDLE: if the candidate set is nonzero, latch the winner index, set vector = VEC_BASE + index*VEC_PASO (truncated to VEC_W), set interrupcion=1, go to REQ. Otherwise stay in IDLE.
- FSM state REQ: interrupcion held at 1 and vector stable.
  - On ack: pendiente[idx]<=0, en_servicio<=one-hot(idx), interrupcion<=0, go to SERVICIO.
  - The request is committed. A mask write, or a higher-priority event, during REQ does not change idx or retract the request.
- FSM state SERVICIO: interrupcion=0; new events still latch into pendiente.
  - On eoi: en_servicio<=0, go to IDLE.
- Latency:
  - Edge sampled at clock edge T0 sets pendiente after T0. interrupcion rises after T1, i.e. 2 cycles from the sampled edge.
  - After eoi at edge Te, the next request can rise after Te+1.
- Simultaneous events:
  - An edge on source idx in the same cycle as ack sets pendiente[idx]=1 (set wins) and is serviced later.
  - ack and eoi together in REQ: ack is taken, eoi ignored.
  - ack outside REQ is ignored. eoi outside SERVICIO is ignored.
  - A mask write in the same cycle as IDLE evaluation uses the old mask.
- vector holds its last value in IDLE and SERVICIO.
- Reset mid-operation (any state) returns to the reset values immediately. Pending and in-service state are discarded.

Test Plan:
- Reset, then mask=4'b0000, pulse irq_in[2] -> pendiente=4'b0100 after the edge; interrupcion=1 two cycles after the sampled edge; vector=1008. ack -> interrupcion=0, en_servicio=4'b0100, pendiente=0. eoi -> en_servicio=0, state IDLE.
- Mask=4'b0000, raise irq_in[3] and irq_in[1] in the same cycle -> vector=1004 first; after ack/eoi -> vector=1012 one cycle later; pendiente empty at the end.
- Reset leaves mask=4'b1111; pulse irq_in[0] -> no interrupcion, pendiente=4'b0001. Write mask=4'b0000 -> interrupcion=1 and vector=1000 two cycles after the write edge.
- While in REQ for source 2, pulse irq_in[0] -> vector stays 1008. After ack and eoi, source 0 is requested with vector=1000.
- In SERVICIO for source 1, pulse irq_in[1] again -> pendiente[1]=1 and interrupcion stays 0 until eoi; then source 1 is re-requested. Also check that ack pulsed in IDLE/SERVICIO and eoi pulsed in IDLE/REQ have no effect.
- Assert reset while in REQ -> interrupcion=0, en_servicio=0, pendiente=0, mask=4'b1111 immediately, without waiting for a clock edge.
